scan_decoder: RTL and testbench
===============================

// Module: scan_decoder
// PURPOSE
//  Parametrised N-to-2^N decoder with active-low outputs and 74x138-style 3-bit enable,
//  extended with registered outputs and an auto-scan engine. Drives digit/row selects of
//  multiplexed 7-seg displays and LED matrices.
//  Manual mode decodes sel_in. Auto mode cycles channels with a dwell time and a blanking gap.
// PARAMETERS
//  SEL_W      3      select width; output width OUT_W = 2**SEL_W
//  ACTIVE_CNT 8      channels scanned in auto mode, 1..OUT_W
//  DWELL_CYC  50000  clocks each channel is driven, >=1
//  BLANK_CYC  100    clocks all outputs high between channels, >=1
// PORTS
//  sys_clk    in   1      clock
//  sys_rst_n  in   1      asynchronous active-low reset
//  en         in   3      {G1,G2A_n,G2B_n}; enabled only when en==3'b100
//  mode       in   1      0 = manual decode, 1 = auto scan
//  sel_in     in   SEL_W  manual channel index
//  sel_out_n  out  OUT_W  registered select, active low, at most one bit low
//  ch_idx     out  SEL_W  channel currently selected or pending
//  ch_strobe  out  1      1-clk pulse in the first DRIVE cycle of each channel
//  frame_done out  1      1-clk pulse in the last DRIVE cycle of channel ACTIVE_CNT-1 (auto only)
// BEHAVIOUR
//  Reset: sel_out_n = all 1s; ch_idx = 0; ch_strobe = 0; frame_done = 0; state = IDLE; timer = 0.
//  States: IDLE, BLANK, DRIVE. sel_out_n is all 1s in IDLE and BLANK.
//   In DRIVE, only bit ch_idx is 0.
//  IDLE -> BLANK on the first clock with en==3'b100. ch_idx loads 0 (auto) or sel_in (manual).
//  BLANK lasts exactly BLANK_CYC clocks, then -> DRIVE.
//  Auto DRIVE lasts exactly DWELL_CYC clocks.
//   Then ch_idx increments, wraps ACTIVE_CNT-1 -> 0, and the block -> BLANK.
//  Manual DRIVE holds while sel_in is stable.
//   If the registered sel_in differs from ch_idx: ch_idx <= sel_in and -> BLANK.
//  Latency: manual sel_in change -> new bit low after 1 + BLANK_CYC clocks.
//  Disable: en != 3'b100 sampled -> next clock state = IDLE, sel_out_n all 1s.
//   ch_idx = 0, timer cleared, pulses 0. Applies mid-BLANK or mid-DRIVE.
//  mode change while enabled: same as disable + re-enable -> BLANK; ch_idx from the new mode.
//  ACTIVE_CNT==1: ch_idx stays 0. ch_strobe and frame_done fire every (BLANK_CYC+DWELL_CYC) clocks.
//  frame_done and ch_strobe coincide only when DWELL_CYC==1.
//  Manual mode: any sel_in in 0..OUT_W-1 is decoded; ACTIVE_CNT is ignored; frame_done stays 0.
//  All outputs come from flops; no combinational path from inputs to outputs.
//  Timer width = clog2(max(DWELL_CYC,BLANK_CYC)+1).
// CONFIGURATION
//  SCAN_DECODER_BLANK_EN defined: behaviour as above.
//  Undefined: BLANK state is removed and BLANK_CYC is ignored.
//   IDLE -> DRIVE directly, 1-clk latency from enable.
//   Channel switches take a single clock edge, old bit high and new bit low together.
//   Manual latency = 1 clock.
// TESTING  (SEL_W=3, ACTIVE_CNT=6, DWELL_CYC=4, BLANK_CYC=2, BLANK_EN defined)
//  1 Reset asserted mid-DRIVE -> sel_out_n=8'hFF, ch_idx=0, pulses 0 immediately, without waiting for a clock.
//  2 en=3'b100, mode=1 -> 2 clks 8'hFF, 4 clks 8'hFE, 2 clks FF, 4 clks 8'hFD, ...
//    Wraps after 8'hDF back to 8'hFE; frame_done in the 4th 8'hDF clk; 6 ch_strobes per frame.
//  3 mode=0, sel_in 0->7 while in DRIVE -> 1 clk old value, 2 clks 8'hFF, then 8'h7F held;
//    ch_idx=7; frame_done never asserts.
//  4 en=3'b110 in the 3rd DRIVE clk of ch 2 -> next clk 8'hFF, IDLE.
//    Restoring 3'b100 restarts at ch 0 after 2 blank clks. Check all 7 non-100 en codes.
//  5 mode 1->0 mid-scan with sel_in=5 -> 8'hFF for 1+2 clks, then 8'hDF.
//  6 BLANK_EN undefined, auto -> 8'hFE x4, 8'hFD x4, ... no 8'hFF gaps.
//    Every clock: popcount(~sel_out_n) <= 1.

Source files
------------

// File: rtl/scan_decoder.sv
// N-to-2^N active-low decoder with 74x138-style enable, registered outputs and an auto-scan engine.
// Define SCAN_DECODER_BLANK_EN to insert an all-high blanking gap between channels.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int ACTIVE_CNT = 8,
  parameter int DWELL_CYC  = 50000,
  parameter int BLANK_CYC  = 100
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [2:0]            en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel_in,
  output logic [2**SEL_W-1:0]   sel_out_n,
  output logic [SEL_W-1:0]      ch_idx,
  output logic                  ch_strobe,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    DWELL_LAST = TW'(DWELL_CYC - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(ACTIVE_CNT - 1);
`ifdef SCAN_DECODER_BLANK_EN
  localparam logic [TW-1:0]    BLANK_LAST = TW'(BLANK_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                r_state, w_state;
  logic [TW-1:0]         r_timer, w_timer;
  logic [SEL_W-1:0]      r_ch, w_ch;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_mode, w_mode;
  logic [2**SEL_W-1:0]   r_out_n, w_out_n;
  logic                  r_strobe, r_frame;
  logic                  w_enabled, w_enter, w_frame;

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_ch      = r_ch;
    w_mode    = r_mode;
    w_enter   = 1'b0;
    w_enabled = (en == 3'b100);
    // A mode flip while running restarts exactly like a disable followed by re-enable.
    if (!w_enabled || (r_state != S_IDLE && mode != r_mode)) begin
      w_state = S_IDLE;
      w_timer = '0;
      w_ch    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_mode  = mode;
          w_ch    = mode ? '0 : sel_in;
          w_timer = '0;
`ifdef SCAN_DECODER_BLANK_EN
          w_state = S_BLANK;
`else
          w_state = S_DRIVE;
          w_enter = 1'b1;
`endif
        end
`ifdef SCAN_DECODER_BLANK_EN
        S_BLANK: begin
          if (r_timer == BLANK_LAST) begin
            w_state = S_DRIVE;
            w_timer = '0;
            w_enter = 1'b1;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
`endif
        S_DRIVE: begin
          if (r_mode) begin
            if (r_timer == DWELL_LAST) begin
              w_timer = '0;
              w_ch    = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
              w_state = S_BLANK;
`else
              w_enter = 1'b1;
`endif
            end else begin
              w_timer = r_timer + 1'b1;
            end
          end else if (r_sel != r_ch) begin
            w_ch = r_sel;
`ifdef SCAN_DECODER_BLANK_EN
            w_state = S_BLANK;
`else
            w_enter = 1'b1;
`endif
          end
        end
        default: begin
          w_state = S_IDLE;
          w_timer = '0;
          w_ch    = '0;
        end
      endcase
    end

    // Outputs are computed from next-state values so the flops present them in the same cycle.
    w_out_n = '1;
    if (w_state == S_DRIVE) w_out_n[w_ch] = 1'b0;
    w_frame = w_mode && (w_state == S_DRIVE) && (w_ch == CH_LAST) && (w_timer == DWELL_LAST);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_ch     <= '0;
      r_sel    <= '0;
      r_mode   <= 1'b0;
      r_out_n  <= '1;
      r_strobe <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_timer  <= w_timer;
      r_ch     <= w_ch;
      r_sel    <= sel_in;
      r_mode   <= w_mode;
      r_out_n  <= w_out_n;
      r_strobe <= w_enter;
      r_frame  <= w_frame;
    end
  end

  assign sel_out_n  = r_out_n;
  assign ch_idx     = r_ch;
  assign ch_strobe  = r_strobe;
  assign frame_done = r_frame;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=3, ACTIVE_CNT=6, DWELL_CYC=4, BLANK_CYC=2).
// Expected sequences follow the blanking gap of whichever build is compiled.
module tb_scan_decoder;
  localparam int DWELL = 4;
  localparam int NCH   = 6;
`ifdef SCAN_DECODER_BLANK_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] en = 3'b000;
  logic       mode = 1'b0;
  logic [2:0] sel_in = 3'd0;
  logic [7:0] sel_out_n;
  logic [2:0] ch_idx;
  logic       ch_strobe, frame_done;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ch_q[$];
  logic [7:0] stb_q[$];
  logic [7:0] fd_q[$];

  scan_decoder #(.SEL_W(3), .ACTIVE_CNT(NCH), .DWELL_CYC(DWELL), .BLANK_CYC(2)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .sel_out_n(sel_out_n), .ch_idx(ch_idx), .ch_strobe(ch_strobe),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] sel_code(input int ch);
    logic [7:0] v;
    v = 8'hFF;
    v[ch] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    check_eq("onehot", 32'($countones(~sel_out_n) <= 1), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] o, input logic [2:0] ch,
                            input logic stb, input logic fd);
    check_eq({tag, "_out"}, sel_out_n, o);
    check_eq({tag, "_ch"}, ch_idx, ch);
    check_eq({tag, "_stb"}, ch_strobe, stb);
    check_eq({tag, "_fd"}, frame_done, fd);
  endtask

  task automatic start_auto(input string tag);
    en = 3'b100;
    mode = 1'b1;
    for (int b = 0; b < BLK; b++) begin
      tick();
      expect_out({tag, "_blank"}, 8'hFF, 3'd0, 1'b0, 1'b0);
    end
    tick();
    expect_out({tag, "_first"}, 8'hFE, 3'd0, 1'b1, 1'b0);
  endtask

  logic [2:0] bad_en [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    expect_out("por", 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("por_state", dbg_state, 2'd0);
    tick();
    tick();
    expect_out("por_hold", 8'hFF, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    en = 3'b100;
    mode = 1'b1;

    // Auto scan: two full frames then the wrap into channel 0
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < NCH; c++) begin
        for (int b = 0; b < BLK; b++) begin
          exp_q.push_back(8'hFF); ch_q.push_back(8'(c)); stb_q.push_back(8'd0); fd_q.push_back(8'd0);
        end
        for (int d = 0; d < DWELL; d++) begin
          exp_q.push_back(sel_code(c)); ch_q.push_back(8'(c));
          stb_q.push_back(8'(d == 0)); fd_q.push_back(8'(d == DWELL - 1 && c == NCH - 1));
        end
      end
    for (int b = 0; b < BLK; b++) begin
      exp_q.push_back(8'hFF); ch_q.push_back(8'd0); stb_q.push_back(8'd0); fd_q.push_back(8'd0);
    end
    exp_q.push_back(8'hFE); ch_q.push_back(8'd0); stb_q.push_back(8'd1); fd_q.push_back(8'd0);
    while (exp_q.size() > 0) begin
      tick();
      expect_out("auto", exp_q.pop_front(), 3'(ch_q.pop_front()),
                 stb_q.pop_front() != 8'd0, fd_q.pop_front() != 8'd0);
    end

    // Asynchronous reset in the middle of a DRIVE cycle with ch_strobe high
    rst_n = 1'b0;
    #1;
    expect_out("rst_mid", 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("rst_mid_state", dbg_state, 2'd0);
    en = 3'b000;
    mode = 1'b0;
    sel_in = 3'd0;
    tick();
    rst_n = 1'b1;

    // Manual decode and channel switching latency
    en = 3'b100;
    for (int b = 0; b < BLK; b++) begin
      tick();
      expect_out("man_blank", 8'hFF, 3'd0, 1'b0, 1'b0);
    end
    tick();
    expect_out("man_ch0", 8'hFE, 3'd0, 1'b1, 1'b0);
    tick();
    tick();
    expect_out("man_ch0_hold", 8'hFE, 3'd0, 1'b0, 1'b0);
    sel_in = 3'd7;
    tick();
    expect_out("man_old", 8'hFE, 3'd0, 1'b0, 1'b0);
    for (int b = 0; b < BLK; b++) begin
      tick();
      expect_out("man_gap7", 8'hFF, 3'd7, 1'b0, 1'b0);
    end
    tick();
    expect_out("man_ch7", 8'h7F, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("man_ch7_hold", 8'h7F, 3'd7, 1'b0, 1'b0);
    end
    sel_in = 3'd3;
    tick();
    expect_out("man_old7", 8'h7F, 3'd7, 1'b0, 1'b0);
    for (int b = 0; b < BLK; b++) begin
      tick();
      expect_out("man_gap3", 8'hFF, 3'd3, 1'b0, 1'b0);
    end
    tick();
    expect_out("man_ch3", 8'hF7, 3'd3, 1'b1, 1'b0);

    // Disable in the 3rd DRIVE clock of channel 2, for every non-enabling code
    en = 3'b000;
    tick();
    expect_out("dis_idle", 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("dis_idle_state", dbg_state, 2'd0);
    for (int k = 0; k < 7; k++) begin
      start_auto("dis_start");
      for (int i = 0; i < 2 * (BLK + DWELL) + 2; i++) tick();
      expect_out("dis_pre", 8'hFB, 3'd2, 1'b0, 1'b0);
      check_eq("dis_pre_state", dbg_state, 2'd2);
      en = bad_en[k];
      tick();
      expect_out("dis_off", 8'hFF, 3'd0, 1'b0, 1'b0);
      check_eq("dis_off_state", dbg_state, 2'd0);
      tick();
      expect_out("dis_stay", 8'hFF, 3'd0, 1'b0, 1'b0);
    end
    start_auto("restart");

    // Mode change auto -> manual in the middle of channel 1
    for (int i = 0; i < DWELL - 1 + BLK + 2; i++) tick();
    expect_out("mode_pre", 8'hFD, 3'd1, 1'b0, 1'b0);
    mode = 1'b0;
    sel_in = 3'd5;
    tick();
    expect_out("mode_off", 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("mode_off_state", dbg_state, 2'd0);
    for (int b = 0; b < BLK; b++) begin
      tick();
      expect_out("mode_gap", 8'hFF, 3'd5, 1'b0, 1'b0);
    end
    tick();
    expect_out("mode_ch5", 8'hDF, 3'd5, 1'b1, 1'b0);
    tick();
    tick();
    expect_out("mode_ch5_hold", 8'hDF, 3'd5, 1'b0, 1'b0);

    // Disable right after enabling (mid-BLANK when blanking is built in)
    en = 3'b000;
    tick();
    en = 3'b100;
    mode = 1'b1;
    tick();
    en = 3'b011;
    tick();
    expect_out("early_off", 8'hFF, 3'd0, 1'b0, 1'b0);
    check_eq("early_off_state", dbg_state, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
